// File: rtl/pc_pkg.sv
// pc_pkg
// Shared definitions for the program-counter unit and its return stack:
//   - PS_* : next-PC select encodings driven on the PS port
//   - rasCountWidth() / RAS_CNT_W : width of the return-stack occupancy count
package pc_pkg;

  // Next-PC select encodings
  localparam logic [2:0] PS_HOLD   = 3'b000;
  localparam logic [2:0] PS_INC    = 3'b001;
  localparam logic [2:0] PS_JUMP   = 3'b010;
  localparam logic [2:0] PS_BRANCH = 3'b011;
  localparam logic [2:0] PS_CALL   = 3'b100;
  localparam logic [2:0] PS_RET    = 3'b101;
  localparam logic [2:0] PS_EXC    = 3'b110;
  localparam logic [2:0] PS_RSVD   = 3'b111;

  // The count must be able to hold RAS_DEPTH itself, hence the extra bit
  function automatic int rasCountWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int RAS_DEPTH_DEFAULT = 4;
  localparam int RAS_CNT_W         = rasCountWidth(RAS_DEPTH_DEFAULT);

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if
// Bundles the fetch-stage control inputs and PC/return-stack status outputs.
//   in            : branch offset (words) or absolute target
//   PS            : next-PC select
//   stall         : freeze PC and return stack
//   PC / PC4      : current PC and PC + INC
//   ras_count     : valid return-stack entries
//   ras_full/ras_empty, err_underflow : return-stack status
// master drives the controls (fetch control / testbench); slave is pc_unit.
interface pc_unit_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 3
);
  logic [WIDTH-1:0] in;
  logic [2:0]       PS;
  logic             stall;
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] PC4;
  logic [CNT_W-1:0] ras_count;
  logic             ras_full;
  logic             ras_empty;
  logic             err_underflow;

  modport master (
    output in, PS, stall,
    input  PC, PC4, ras_count, ras_full, ras_empty, err_underflow
  );

  modport slave (
    input  in, PS, stall,
    output PC, PC4, ras_count, ras_full, ras_empty, err_underflow
  );
endinterface

// File: rtl/pc_unit_return_stack.sv
// return_stack
// Circular return-address stack with a top pointer.
//   clock, reset : rising-edge clock, async active-high reset
//   push / din   : write din at top+1 and advance the pointer
//   pop          : drop the top entry (top is read combinationally)
//   top          : entry currently at the top pointer
//   count        : valid entries, saturates at RAS_DEPTH on overflow
//   full / empty : count == RAS_DEPTH / count == 0
//   underflow    : combinational flag, pop requested while empty
module return_stack
  import pc_pkg::*;
#(
  parameter  int WIDTH     = 64,
  parameter  int RAS_DEPTH = 4,
  localparam int CNT_W     = rasCountWidth(RAS_DEPTH),
  localparam int PTR_W     = $clog2(RAS_DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             underflow
);

  logic [WIDTH-1:0] r_mem [RAS_DEPTH];
  logic [PTR_W-1:0] r_top;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_nextTop;

  // Pointer width equals log2(depth), so +1 wraps mod RAS_DEPTH for free
  assign w_nextTop = r_top + PTR_W'(1);

  assign top       = r_mem[r_top];
  assign count     = r_count;
  assign full      = (r_count == CNT_W'(RAS_DEPTH));
  assign empty     = (r_count == '0);
  assign underflow = pop & empty;

  // A push while full overwrites the oldest entry: the pointer keeps
  // circling and the count simply stays saturated. A pop on an empty
  // stack changes nothing here; the caller sees underflow instead.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RAS_DEPTH; i++) r_mem[i] <= '0;
      r_top   <= '0;
      r_count <= '0;
    end else if (push) begin
      r_mem[w_nextTop] <= din;
      r_top            <= w_nextTop;
      if (!full) r_count <= r_count + CNT_W'(1);
    end else if (pop && !empty) begin
      r_top   <= r_top - PTR_W'(1);
      r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit
// Fetch-stage program counter: selects the next PC each clock from hold,
// increment, jump, PC-relative branch, call, return or exception vector.
//   clock, reset : rising-edge clock, async active-high reset
//   bus (slave)  : in, PS, stall inputs; PC, PC4, ras_count, ras_full,
//                  ras_empty, err_underflow outputs
module pc_unit
  import pc_pkg::*;
#(
  parameter  int               WIDTH     = 64,
  parameter  int               INC       = 4,
  parameter  int               SHIFT     = 2,
  parameter  int               RAS_DEPTH = 4,
  parameter  logic [WIDTH-1:0] RESET_VEC = '0,
  parameter  logic [WIDTH-1:0] EXC_VEC   = WIDTH'('h100),
  localparam int               CNT_W     = rasCountWidth(RAS_DEPTH)
) (
  input logic clock,
  input logic reset,
  pc_unit_if.slave bus
);

  logic [WIDTH-1:0] r_pc;
  logic             r_errUnderflow;
  logic [WIDTH-1:0] w_pc4;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_nextPc;
  logic [WIDTH-1:0] w_rasTop;
  logic             w_rasEmpty;
  logic             w_rasFull;
  logic [CNT_W-1:0] w_rasCount;
  logic             w_push;
  logic             w_pop;
  logic             w_underflow;

  // Both adders wrap modulo 2^WIDTH; no carry is kept
  assign w_pc4    = r_pc + WIDTH'(INC);
  assign w_target = w_pc4 + (bus.in << SHIFT);

  // Next-PC mux; push/pop are suppressed while stalled so the stack freezes
  always_comb begin
    w_nextPc = w_pc4;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    case (bus.PS)
      PS_HOLD:   w_nextPc = r_pc;
      PS_INC:    w_nextPc = w_pc4;
      PS_JUMP:   w_nextPc = bus.in;
      PS_BRANCH: w_nextPc = w_target;
      PS_CALL: begin
        w_nextPc = w_target;
        w_push   = !bus.stall;
      end
      PS_RET: begin
        w_nextPc = w_rasEmpty ? w_pc4 : w_rasTop;
        w_pop    = !bus.stall;
      end
      PS_EXC:    w_nextPc = EXC_VEC;
      default:   w_nextPc = w_pc4;
    endcase
  end

  return_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_returnStack (
    .clock     (clock),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .din       (w_pc4),
    .top       (w_rasTop),
    .count     (w_rasCount),
    .full      (w_rasFull),
    .empty     (w_rasEmpty),
    .underflow (w_underflow)
  );

  // The underflow flag is registered alongside the PC and, like it,
  // holds its value through a stall
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc           <= RESET_VEC;
      r_errUnderflow <= 1'b0;
    end else if (!bus.stall) begin
      r_pc           <= w_nextPc;
      r_errUnderflow <= w_underflow;
    end
  end

  assign bus.PC            = r_pc;
  assign bus.PC4           = w_pc4;
  assign bus.ras_count     = w_rasCount;
  assign bus.ras_full      = w_rasFull;
  assign bus.ras_empty     = w_rasEmpty;
  assign bus.err_underflow = r_errUnderflow;

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit that generalises the fetch-stage PC. It holds the current PC and selects the next PC each clock: hold, increment, absolute jump, PC-relative branch, call, return, or exception vector. Calls and returns use an internal return-address stack (RAS). The block sits at the head of the fetch stage. Its outputs are PC (instruction-memory address) and PC4 (link value to the register file).

## Interface
Parameters:
- WIDTH, 64, PC/address width in bits.
- INC, 4, byte increment per sequential instruction.
- SHIFT, 2, left shift applied to the branch offset before adding.
- RAS_DEPTH, 4, return-stack entries (power of two, ≥2).
- RESET_VEC, 0, PC value after reset.
- EXC_VEC, 'h100, PC value loaded on an exception.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- in  in  WIDTH  branch offset (word count) or absolute target.
- PS  in  3  next-PC select, encodings below.
- stall  in  1  freeze PC and RAS this cycle.
- PC  out  WIDTH  current PC, registered.
- PC4  out  WIDTH  PC + INC, combinational from PC.
- ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries, registered.
- ras_full  out  1  ras_count == RAS_DEPTH.
- ras_empty  out  1  ras_count == 0.
- err_underflow  out  1  one-cycle pulse after a return issued on an empty RAS.

## Operation
PS encodings and the next PC each selects:
- 000 HOLD: next PC = PC.
- 001 INC: next PC = PC4.
- 010 JUMP: next PC = in.
- 011 BRANCH: next PC = PC4 + (in << SHIFT).
- 100 CALL: next PC = PC4 + (in << SHIFT); push PC4 onto the RAS.
- 101 RET: next PC = RAS top; pop the RAS.
- 110 EXC: next PC = EXC_VEC; RAS unchanged.
- 111 reserved, treated as INC.

Rules:
- All arithmetic is modulo 2^WIDTH. Overflow wraps silently; there is no carry output.
- stall=1 overrides PS: PC, RAS contents, ras_count and err_underflow all hold, and no push or pop occurs.
- CALL when the RAS is full: the oldest entry is overwritten (circular buffer) and ras_count stays at RAS_DEPTH.
- RET when the RAS is empty: next PC = PC4, ras_count stays 0, and err_underflow pulses high for the next cycle.
- RAS implementation: circular buffer with a top pointer. A push writes at top+1 and advances the pointer. A pop returns the top entry and decrements the pointer. Pointer arithmetic wraps mod RAS_DEPTH.

## Timing
- Reset (asynchronous, takes effect immediately on assertion):
  - PC = RESET_VEC, PC4 = RESET_VEC + INC.
  - ras_count = 0, ras_empty = 1, ras_full = 0, err_underflow = 0.
  - RAS entries are cleared to 0.
- PC updates on the rising clock edge where reset is low. The new value is visible in the same cycle after the edge.
- Select-to-PC latency is 1 cycle. PC4 follows PC combinationally with 0 latency.
- A RAS push or pop commits on the same edge as the PC update. A CALL immediately followed by a RET returns the pushed PC4.
- err_underflow is registered: high exactly one cycle, then low unless another underflowing RET occurs.
- Reset asserted mid-operation abandons any pending push or pop. The first edge after reset deasserts uses the PS presented on that edge.

## Structure
- Shared package pc_pkg holds:
  - the PS encoding constants (PS_HOLD … PS_EXC);
  - the localparam computing the ras_count width.
- Sub-module return_stack (parameters WIDTH, RAS_DEPTH):
  - ports: clock, reset, push, pop, din, top, count, full, empty, underflow;
  - implements the circular-overwrite and underflow rules above.
- pc_unit contains the next-PC mux, the two adders and the PC register.

## Test plan
- Reset with RESET_VEC=0, then PS=001 for 3 cycles: PC = 0, 4, 8, 12, with PC4 always PC+4.
- PC=0x100, PS=011, in=3: PC = 0x110. Then in=-2 (all ones except bit 0): PC = 0x10C.
- PC=0x200: CALL in=0x10, then RET. PC = 0x244, then 0x204; ras_count goes 0→1→0.
- RAS_DEPTH=4: five CALLs pushing A..E, then five RETs. Returns are E, D, C, B. The fifth RET yields PC4, ras_count stays 0, and err_underflow pulses once.
- stall=1 held with PS=100 for 2 cycles: PC and ras_count unchanged. Deassert stall: the push occurs.
- PC=2^WIDTH−4, PS=001: PC wraps to 0. Then assert reset mid-stream with the RAS holding 2 entries: PC=RESET_VEC and ras_count=0 immediately, with no clock edge required.
